nx_ia_mem_arbiter: RTL and testbench
====================================

NX_IA_MEM_ARBITER -- requirements
Module: nx_ia_mem_arbiter

Interface
REQ-001 Parameter N_HW, default 2, number of hardware requesters (1..4).
REQ-002 Parameter N_ADDR_BITS, default 5, memory address width.
REQ-003 Parameter N_DATA_BITS, default 64, memory data width.
REQ-004 Parameter SW_WAIT_MAX, default 8, max cycles the software port waits before forced priority (2..15).
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 sw_cs / sw_we  in  1 / 1  software (indirect-access controller) access request / write qualifier.
REQ-008 sw_add / sw_wdat  in  N_ADDR_BITS / N_DATA_BITS  software address / write data.
REQ-009 yield  in  1  controller timer request for immediate software priority.
REQ-010 ia_enable  in  1  controller enable; 0 = table under init/powerdown, hardware locked out.
REQ-011 grant  out  1  software access issued this cycle.
REQ-012 sw_rdat  out  N_DATA_BITS  software read data.
REQ-013 hw_req / hw_we  in  N_HW / N_HW  per-requester request / write qualifier.
REQ-014 hw_add / hw_wdat  in  N_HW*N_ADDR_BITS / N_HW*N_DATA_BITS  packed per-requester address / data, requester i at slice i.
REQ-015 hw_gnt  out  N_HW  one-hot access issued this cycle.
REQ-016 hw_rvld / hw_rdat  out  N_HW / N_DATA_BITS  read-return strobe (one-hot) / shared return data.
REQ-017 mem_cs, mem_we, mem_add, mem_wdat  out  1,1,N_ADDR_BITS,N_DATA_BITS  single-port RAM controls.
REQ-018 mem_rdat  in  N_DATA_BITS  RAM read data, valid exactly 1 cycle after a read mem_cs.

Function
REQ-019 At most one access per cycle; grant and hw_gnt combinational, mutually exclusive, at most one bit set.
REQ-020 Software wins when sw_cs=1 and any of: yield=1, ia_enable=0, sw_wait_q==SW_WAIT_MAX, no eligible hw_req.
REQ-021 Otherwise, hardware wins via round-robin: search starts at rr_q, first eligible requester granted.
REQ-022 hw_req[i] eligible only when ia_enable=1; with ia_enable=0 every hw_gnt=0.
REQ-023 rr_q updates to (granted index+1) mod N_HW on hardware grant only; otherwise holds.
REQ-024 sw_wait_q (4 bits): cleared when grant=1 or sw_cs=0; else increments when sw_cs=1, saturating at SW_WAIT_MAX.
REQ-025 mem_cs = grant | (|hw_gnt); mem_we/mem_add/mem_wdat muxed from winner; with no winner mem_we=0, mem_add=0, mem_wdat=0.
REQ-026 Read return register (rd_sw_q, rd_hw_q[N_HW]) loads the winner identity when the access is a read, else clears; 1-cycle pipeline.
REQ-027 hw_rvld = rd_hw_q; hw_rdat = mem_rdat when |rd_hw_q, else 0.
REQ-028 sw_rdat = mem_rdat when rd_sw_q=1, else sw_hold_q; sw_hold_q captures mem_rdat when rd_sw_q=1.
REQ-029 Writes return nothing; read then write back-to-back from any mix of ports is legal every cycle.
REQ-030 Simultaneous yield and hw_req: software granted, hw requests stall (hold until hw_gnt).
REQ-031 A requester dropping hw_req without hw_gnt is legal; no state retained for it.
REQ-032 ia_enable falling while a hardware read is in flight: return still delivered next cycle.

Reset
REQ-033 rst_n=0 asynchronously: rr_q=0, sw_wait_q=0, rd_sw_q=0, rd_hw_q=0, sw_hold_q=0.
REQ-034 During reset and first cycle after: all outputs 0 except those combinationally driven by inputs per REQ-019..025.
REQ-035 Reset mid-read drops the pending return; no hw_rvld after reset release.

Verification
REQ-036 sw_cs=1 read addr 3, no hw_req -> grant=1 same cycle, mem_add=3, next cycle sw_rdat=mem_rdat, held after.
REQ-037 hw_req=2'b11 held 4 cycles, sw_cs=0 -> hw_gnt sequence 01,10,01,10; hw_rvld follows one cycle later.
REQ-038 hw_req=2'b11 and sw_cs=1 held, yield=0 -> grant=1 on cycle 9 (sw_wait_q reaches 8), sw_wait_q then 0.
REQ-039 hw_req=2'b01, sw_cs=1, yield=1 -> grant=1, hw_gnt=0 that cycle, hw_gnt=01 after sw_cs drops.
REQ-040 ia_enable=0, hw_req=2'b11, sw_cs=1 write addr 31 -> grant=1, mem_we=1, hw_gnt=0 every cycle.
REQ-041 rst_n pulse low during hw read cycle -> no hw_rvld next cycle, rr_q=0, sw_rdat=0.

Source files
------------

// File: rtl/nx_ia_mem_arbiter.sv
// nx_ia_mem_arbiter
// Shares one single-port RAM between a software indirect-access port and
// N_HW hardware requesters.  At most one access is issued per cycle.
// Software wins on yield, when the table is disabled, when it has waited
// SW_WAIT_MAX cycles, or when no hardware requester is eligible.
// Otherwise the hardware requesters share the RAM by round-robin.
// Read data comes back one cycle after the access and is steered to the
// port that issued it.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   sw_cs/sw_we            software request / write qualifier
//   sw_add/sw_wdat         software address / write data
//   yield                  immediate software priority request
//   ia_enable              0 locks out all hardware requesters
//   grant                  software access issued this cycle
//   sw_rdat                software read data (held between reads)
//   hw_req/hw_we           per-requester request / write qualifier
//   hw_add/hw_wdat         packed per-requester address / write data
//   hw_gnt                 one-hot hardware access issued this cycle
//   hw_rvld/hw_rdat        one-hot read-return strobe / shared return data
//   mem_cs/mem_we          RAM select / write enable
//   mem_add/mem_wdat       RAM address / write data
//   mem_rdat               RAM read data, valid one cycle after a read
module nx_ia_mem_arbiter #(
  parameter int N_HW        = 2,
  parameter int N_ADDR_BITS = 5,
  parameter int N_DATA_BITS = 64,
  parameter int SW_WAIT_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sw_cs,
  input  logic                          sw_we,
  input  logic [N_ADDR_BITS-1:0]        sw_add,
  input  logic [N_DATA_BITS-1:0]        sw_wdat,
  input  logic                          yield,
  input  logic                          ia_enable,
  output logic                          grant,
  output logic [N_DATA_BITS-1:0]        sw_rdat,
  input  logic [N_HW-1:0]               hw_req,
  input  logic [N_HW-1:0]               hw_we,
  input  logic [N_HW*N_ADDR_BITS-1:0]   hw_add,
  input  logic [N_HW*N_DATA_BITS-1:0]   hw_wdat,
  output logic [N_HW-1:0]               hw_gnt,
  output logic [N_HW-1:0]               hw_rvld,
  output logic [N_DATA_BITS-1:0]        hw_rdat,
  output logic                          mem_cs,
  output logic                          mem_we,
  output logic [N_ADDR_BITS-1:0]        mem_add,
  output logic [N_DATA_BITS-1:0]        mem_wdat,
  input  logic [N_DATA_BITS-1:0]        mem_rdat
);

  localparam int RR_W = (N_HW > 1) ? $clog2(N_HW) : 1;

  logic [RR_W-1:0]        rr_q;
  logic [RR_W-1:0]        rr_d;
  logic [3:0]             sw_wait_q;
  logic                   rd_sw_q;
  logic [N_HW-1:0]        rd_hw_q;
  logic [N_DATA_BITS-1:0] sw_hold_q;

  logic [N_HW-1:0]        hw_elig;
  logic                   sw_win;
  logic                   hw_found;
  logic [RR_W-1:0]        hw_idx;
  logic [RR_W:0]          cand;
  logic [RR_W:0]          rr_inc;

  // Arbitration: software override first, then a round-robin scan that
  // starts at rr_q and wraps, taking the first eligible requester.
  always_comb begin
    hw_elig  = hw_req & {N_HW{ia_enable}};
    sw_win   = sw_cs & (yield | ~ia_enable |
                        (sw_wait_q == 4'(SW_WAIT_MAX)) | ~(|hw_elig));
    hw_found = 1'b0;
    hw_idx   = '0;
    cand     = '0;
    for (int k = 0; k < N_HW; k++) begin
      cand = {1'b0, rr_q} + (RR_W+1)'(k);
      if (cand >= (RR_W+1)'(N_HW))
        cand = cand - (RR_W+1)'(N_HW);
      if (!hw_found && hw_elig[cand[RR_W-1:0]]) begin
        hw_found = 1'b1;
        hw_idx   = cand[RR_W-1:0];
      end
    end

    grant  = sw_win;
    hw_gnt = '0;
    if (!sw_win && hw_found)
      hw_gnt[hw_idx] = 1'b1;

    // Pointer moves past the winner only when hardware actually wins.
    rr_inc = {1'b0, hw_idx} + (RR_W+1)'(1);
    if (rr_inc == (RR_W+1)'(N_HW))
      rr_inc = '0;
    rr_d = rr_q;
    if (!sw_win && hw_found)
      rr_d = rr_inc[RR_W-1:0];
  end

  // RAM port mux; idle cycles drive all-zero controls.
  always_comb begin
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    mem_add  = '0;
    mem_wdat = '0;
    if (sw_win) begin
      mem_cs   = 1'b1;
      mem_we   = sw_we;
      mem_add  = sw_add;
      mem_wdat = sw_wdat;
    end else if (hw_found) begin
      mem_cs   = 1'b1;
      mem_we   = hw_we[hw_idx];
      mem_add  = hw_add[int'(hw_idx)*N_ADDR_BITS +: N_ADDR_BITS];
      mem_wdat = hw_wdat[int'(hw_idx)*N_DATA_BITS +: N_DATA_BITS];
    end
  end

  // Arbiter state and the one-cycle read-return pipeline.  sw_hold_q keeps
  // the last software read visible after the RAM output moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      sw_wait_q <= '0;
      rd_sw_q   <= 1'b0;
      rd_hw_q   <= '0;
      sw_hold_q <= '0;
    end else begin
      rr_q <= rr_d;
      if (!sw_cs || sw_win)
        sw_wait_q <= '0;
      else if (sw_wait_q != 4'(SW_WAIT_MAX))
        sw_wait_q <= sw_wait_q + 4'd1;
      rd_sw_q <= sw_win & ~sw_we;
      rd_hw_q <= hw_gnt & ~hw_we;
      if (rd_sw_q)
        sw_hold_q <= mem_rdat;
    end
  end

  assign hw_rvld = rd_hw_q;
  assign hw_rdat = (|rd_hw_q) ? mem_rdat : '0;
  assign sw_rdat = rd_sw_q ? mem_rdat : sw_hold_q;

endmodule

// File: tb/tb_nx_ia_mem_arbiter.sv
// tb_nx_ia_mem_arbiter
// Directed bench for nx_ia_mem_arbiter with default parameters (2 hardware
// requesters, 32 x 64 RAM).  A small RAM model answers mem_cs one cycle
// later; each location starts as pattern(addr).  Inputs change on the
// falling edge and outputs are compared 1 ns later.
module tb_nx_ia_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sw_cs, sw_we, yield, ia_enable;
  logic [4:0]   sw_add;
  logic [63:0]  sw_wdat;
  logic         grant;
  logic [63:0]  sw_rdat;
  logic [1:0]   hw_req, hw_we;
  logic [9:0]   hw_add;
  logic [127:0] hw_wdat;
  logic [1:0]   hw_gnt, hw_rvld;
  logic [63:0]  hw_rdat;
  logic         mem_cs, mem_we;
  logic [4:0]   mem_add;
  logic [63:0]  mem_wdat;
  logic [63:0]  mem_rdat = '0;

  logic [63:0]  ram [0:31];
  int           checks   = 0;
  int           failures = 0;

  localparam logic [63:0] DAT_X = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DAT_Y = 64'h5555_AAAA_1234_0002;
  localparam logic [63:0] DAT_Z = 64'hFEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  nx_ia_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .sw_cs(sw_cs), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat),
    .yield(yield), .ia_enable(ia_enable),
    .grant(grant), .sw_rdat(sw_rdat),
    .hw_req(hw_req), .hw_we(hw_we), .hw_add(hw_add), .hw_wdat(hw_wdat),
    .hw_gnt(hw_gnt), .hw_rvld(hw_rvld), .hw_rdat(hw_rdat),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_add(mem_add),
    .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
  );

  function automatic logic [63:0] pattern(input int a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  // Single-port RAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_add] <= mem_wdat;
      else        mem_rdat     <= ram[mem_add];
    end
  end

  // Drive one cycle's inputs on the falling edge.  Requester 0 uses
  // address 7, requester 1 address 9.
  task automatic applyStimulus(input logic cs, input logic we,
                               input logic [4:0] add, input logic [63:0] wdat,
                               input logic yl, input logic en,
                               input logic [1:0] req, input logic [1:0] hwe);
    @(negedge clk);
    sw_cs     = cs;
    sw_we     = we;
    sw_add    = add;
    sw_wdat   = wdat;
    yield     = yl;
    ia_enable = en;
    hw_req    = req;
    hw_we     = hwe;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = pattern(i);
    hw_add  = {5'd9, 5'd7};
    hw_wdat = {64'h1111_0000_0000_0001, 64'h0000_2222_0000_0000};
    rst_n = 1'b0;
    sw_cs = 0; sw_we = 0; sw_add = 0; sw_wdat = 0; yield = 0;
    ia_enable = 0; hw_req = 0; hw_we = 0;

    // Reset state
    @(negedge clk); #1;
    checkOutput("rst_grant",   64'(grant),   64'd0);
    checkOutput("rst_hw_gnt",  64'(hw_gnt),  64'd0);
    checkOutput("rst_mem_cs",  64'(mem_cs),  64'd0);
    checkOutput("rst_mem_add", 64'(mem_add), 64'd0);
    checkOutput("rst_sw_rdat", sw_rdat,      64'd0);
    checkOutput("rst_hw_rvld", 64'(hw_rvld), 64'd0);
    checkOutput("rst_hw_rdat", hw_rdat,      64'd0);
    rst_n = 1'b1;

    // Software read of address 3 with no hardware traffic
    applyStimulus(1, 0, 5'd3, '0, 0, 1, 2'b00, 2'b00);
    checkOutput("sw_rd_grant",  64'(grant),   64'd1);
    checkOutput("sw_rd_memcs",  64'(mem_cs),  64'd1);
    checkOutput("sw_rd_memadd", 64'(mem_add), 64'd3);
    checkOutput("sw_rd_memwe",  64'(mem_we),  64'd0);
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b00, 2'b00);
    checkOutput("sw_rd_data",   sw_rdat,      pattern(3));
    checkOutput("sw_idle_gnt",  64'(grant),   64'd0);
    // Hardware read moves mem_rdat; software data must stay held
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b10, 2'b00);
    checkOutput("hw1_gnt",      64'(hw_gnt),  64'd2);
    checkOutput("hw1_memadd",   64'(mem_add), 64'd9);
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b00, 2'b00);
    checkOutput("hw1_rvld",     64'(hw_rvld), 64'd2);
    checkOutput("hw1_rdat",     hw_rdat,      pattern(9));
    checkOutput("sw_rd_held",   sw_rdat,      pattern(3));

    // Software write of address 5
    applyStimulus(1, 1, 5'd5, DAT_X, 0, 1, 2'b00, 2'b00);
    checkOutput("sw_wr_grant",  64'(grant),   64'd1);
    checkOutput("sw_wr_memwe",  64'(mem_we),  64'd1);
    checkOutput("sw_wr_memadd", 64'(mem_add), 64'd5);
    checkOutput("sw_wr_wdat",   mem_wdat,     DAT_X);

    // Round-robin between two hardware readers
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b11, 2'b00);
      checkOutput($sformatf("rr_gnt%0d", c), 64'(hw_gnt),
                  (c % 2 == 0) ? 64'd1 : 64'd2);
      checkOutput($sformatf("rr_add%0d", c), 64'(mem_add),
                  (c % 2 == 0) ? 64'd7 : 64'd9);
      if (c > 0) begin
        checkOutput($sformatf("rr_rvld%0d", c), 64'(hw_rvld),
                    (c % 2 == 0) ? 64'd2 : 64'd1);
        checkOutput($sformatf("rr_rdat%0d", c), hw_rdat,
                    (c % 2 == 0) ? pattern(9) : pattern(7));
      end
    end
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b00, 2'b00);
    checkOutput("rr_tail_gnt",  64'(hw_gnt),  64'd0);
    checkOutput("rr_tail_rvld", 64'(hw_rvld), 64'd2);
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b00, 2'b00);
    checkOutput("rr_end_rvld",  64'(hw_rvld), 64'd0);
    checkOutput("rr_end_rdat",  hw_rdat,      64'd0);

    // Starvation guard: software waits 8 cycles then wins on the 9th
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(1, 0, 5'd5, '0, 0, 1, 2'b11, 2'b00);
      checkOutput($sformatf("wait_grant%0d", c), 64'(grant),
                  (c == 9) ? 64'd1 : 64'd0);
      checkOutput($sformatf("wait_hwgnt%0d", c), 64'(hw_gnt),
                  (c == 9) ? 64'd0 : ((c % 2 == 1) ? 64'd1 : 64'd2));
    end
    checkOutput("wait_memadd", 64'(mem_add), 64'd5);
    applyStimulus(1, 0, 5'd5, '0, 0, 1, 2'b11, 2'b00);
    checkOutput("wait_cleared", 64'(grant),  64'd0);
    checkOutput("wait_hw_back", 64'(hw_gnt), 64'd1);
    checkOutput("wait_rdat",    sw_rdat,     DAT_X);

    // Yield beats a pending hardware request, which stalls until served
    applyStimulus(1, 1, 5'd2, DAT_Y, 1, 1, 2'b01, 2'b00);
    checkOutput("yield_grant", 64'(grant),  64'd1);
    checkOutput("yield_hwgnt", 64'(hw_gnt), 64'd0);
    checkOutput("yield_memwe", 64'(mem_we), 64'd1);
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b01, 2'b00);
    checkOutput("yield_after", 64'(hw_gnt), 64'd1);
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b00, 2'b00);
    checkOutput("yield_rvld",  64'(hw_rvld), 64'd1);
    checkOutput("yield_rdat",  hw_rdat,      pattern(7));

    // Hardware read in flight when ia_enable drops still returns
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b10, 2'b00);
    checkOutput("dis_gnt",  64'(hw_gnt), 64'd2);
    applyStimulus(0, 0, 5'd0, '0, 0, 0, 2'b11, 2'b00);
    checkOutput("dis_lock", 64'(hw_gnt),  64'd0);
    checkOutput("dis_rvld", 64'(hw_rvld), 64'd2);
    checkOutput("dis_rdat", hw_rdat,      pattern(9));

    // Disabled table: software write to address 31 every cycle
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 1, 5'd31, DAT_Z, 0, 0, 2'b11, 2'b00);
      checkOutput($sformatf("dis_wr_grant%0d", c), 64'(grant),  64'd1);
      checkOutput($sformatf("dis_wr_we%0d", c),    64'(mem_we), 64'd1);
      checkOutput($sformatf("dis_wr_hw%0d", c),    64'(hw_gnt), 64'd0);
    end
    checkOutput("dis_wr_add", 64'(mem_add), 64'd31);
    applyStimulus(0, 0, 5'd0, '0, 0, 0, 2'b11, 2'b00);
    checkOutput("idle_memcs",  64'(mem_cs),  64'd0);
    checkOutput("idle_memadd", 64'(mem_add), 64'd0);
    checkOutput("idle_wdat",   mem_wdat,     64'd0);

    // Back-to-back software reads of the two written locations
    applyStimulus(1, 0, 5'd2, '0, 0, 1, 2'b00, 2'b00);
    applyStimulus(1, 0, 5'd31, '0, 0, 1, 2'b00, 2'b00);
    checkOutput("b2b_rd_y", sw_rdat, DAT_Y);
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b00, 2'b00);
    checkOutput("b2b_rd_z", sw_rdat, DAT_Z);

    // Reset pulse across a hardware read cycle
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b01, 2'b00);
    checkOutput("rstrd_gnt", 64'(hw_gnt), 64'd1);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b11, 2'b00);
    checkOutput("rstrd_rvld", 64'(hw_rvld), 64'd0);
    checkOutput("rstrd_swrd", sw_rdat,      64'd0);
    checkOutput("rstrd_rr",   64'(hw_gnt),  64'd1);
    applyStimulus(0, 0, 5'd0, '0, 0, 1, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
